// File: rtl/csa_multiword_sequencer.sv
// rtl/csa_multiword_sequencer.sv - wide adder built from one carry_select_adder, one slice per cycle
// Optional subtract mode enabled by defining CSA_SEQ_SUB_EN.

module carry_select_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic [LO:0] lo_sum;
  logic [HI:0] hi_sum0;
  logic [HI:0] hi_sum1;

  // Upper half is computed for both carry-in values and picked by the lower half's carry.
  assign lo_sum  = {1'b0, a_i[LO-1:0]} + {1'b0, b_i[LO-1:0]} + {{LO{1'b0}}, cin_i};
  assign hi_sum0 = {1'b0, a_i[WIDTH-1:LO]} + {1'b0, b_i[WIDTH-1:LO]};
  assign hi_sum1 = {1'b0, a_i[WIDTH-1:LO]} + {1'b0, b_i[WIDTH-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign {cout_o, sum_o} = lo_sum[LO] ? {hi_sum1, lo_sum[LO-1:0]}
                                      : {hi_sum0, lo_sum[LO-1:0]};
endmodule

module csa_multiword_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       state_q;
  logic [WORDS-1:0][WIDTH-1:0]  a_q;
  logic [WORDS-1:0][WIDTH-1:0]  b_q;
  logic [WORDS-1:0][WIDTH-1:0]  sum_q;
  logic [IDX_W-1:0]             idx_q;
  logic                         carry_q;
  logic                         sub_q;
  logic                         cout_q;
  logic                         in_ready_q;
  logic                         out_valid_q;
  logic                         busy_q;

  logic [WIDTH-1:0]             slice_b_d;
  logic [WIDTH-1:0]             slice_sum_d;
  logic                         slice_cout_d;
  logic                         sub_d;
  logic                         carry_init_d;

`ifdef CSA_SEQ_SUB_EN
  assign sub_d        = in_sub;
  assign carry_init_d = in_sub ? 1'b1 : in_cin;
`else
  assign sub_d        = 1'b0;
  assign carry_init_d = in_cin;
`endif

  // Subtraction is A + ~B + 1; the +1 comes from the carry seeded at accept.
  assign slice_b_d = b_q[idx_q] ^ {WIDTH{sub_q}};

  carry_select_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a_q[idx_q]),
    .b_i    (slice_b_d),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_d),
    .cout_o (slice_cout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            sub_q      <= sub_d;
            carry_q    <= carry_init_d;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[idx_q] <= slice_sum_d;
          carry_q      <= slice_cout_d;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_cout_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          // A request seen in this cycle waits; in_ready only returns after the hand-off edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_csa_multiword_sequencer.sv
// tb/tb_csa_multiword_sequencer.sv - self-checking bench for csa_multiword_sequencer (WIDTH=8, WORDS=4)
// Subtract checks are included when CSA_SEQ_SUB_EN is defined.

module tb_csa_multiword_sequencer;
  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int TW    = WIDTH * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_a = '0;
  logic [TW-1:0] in_b = '0;
  logic          in_cin = 1'b0;
  logic          sub_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_sum;
  logic          out_cout;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_multiword_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CSA_SEQ_SUB_EN
    .in_sub    (sub_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW:0]   exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TW:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                        input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                          input logic sub);
    int w;
    in_a = a; in_b = b; in_cin = cin; sub_in = sub; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("accept_bound", {63'd0, w < 20}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_in_run", {63'd0, in_ready}, 64'd0);
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(WORDS));
  endtask

  task automatic finish_op(input int stall, input logic [TW:0] exp, input string name);
    chk(name, {31'd0, out_cout, out_sum}, {31'd0, exp});
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      tick();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_hold", {31'd0, out_cout, out_sum}, {31'd0, exp});
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rc;
    logic          rs;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 33'h0_0100_0101};

    repeat (3) tick();
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_sum", {31'd0, out_cout, out_sum}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      wait_done();
      finish_op(i % 3, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back: second request arrives during the DONE hand-off cycle.
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done();
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("b2b_hold", {31'd0, out_cout, out_sum}, 64'h0_0000_0100);
      chk("b2b_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    in_a = 32'h0000_0002; in_b = 32'h0000_0003; in_cin = 1'b0; sub_in = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_not_accepted_busy", {63'd0, busy}, 64'd0);
    chk("b2b_in_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_accepted_busy", {63'd0, busy}, 64'd1);
    wait_done();
    finish_op(0, 33'h0_0000_0005, "b2b_second");

    // Reset asserted while slice 2 is in flight.
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", {31'd0, out_cout, out_sum}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      chk("rst_no_valid", {63'd0, out_valid}, 64'd0);
    end

`ifdef CSA_SEQ_SUB_EN
    start_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    wait_done();
    finish_op(1, 33'h0_FFFF_FFFE, "sub_borrow");
    start_op(32'h0000_0009, 32'h0000_0007, 1'b0, 1'b1);
    wait_done();
    finish_op(0, 33'h1_0000_0002, "sub_no_borrow");
`endif

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
`ifdef CSA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      start_op(ra, rb, rc, rs);
      wait_done();
      finish_op(int'($urandom_range(0, 3)), model(ra, rb, rc, rs), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
